// File: rtl/mux_n_pipe.sv
// N-way WIDTH-bit selector with a registered valid/ready output stage and a
// one-entry skid register, so the block runs at full rate and stalls cleanly.
module mux_n_pipe #(
   parameter int WIDTH = 32,
   parameter int N_IN  = 3,
   parameter int SEL_W = 2,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]      in_sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_sel_err,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CNT_W-1:0]      err_cnt,
   input  logic                  err_clr
);

   localparam logic [SEL_W:0]   LP_N_IN    = (SEL_W+1)'(N_IN);
   localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

   logic [WIDTH-1:0] w_selData;
   logic             w_selErr;
   logic             w_acc;
   logic             w_adv;

   logic             r_oValid;
   logic [WIDTH-1:0] r_oData;
   logic             r_oErr;
   logic             r_sValid;
   logic [WIDTH-1:0] r_sData;
   logic             r_sErr;
   logic             r_inReady;
   logic [CNT_W-1:0] r_errCnt;

   logic             w_oValidNext;
   logic [WIDTH-1:0] w_oDataNext;
   logic             w_oErrNext;
   logic             w_sValidNext;
   logic [WIDTH-1:0] w_sDataNext;
   logic             w_sErrNext;

   // When N_IN fills the select space this compare folds to a constant 0.
   assign w_selErr = ({1'b0, in_sel} >= LP_N_IN);

   always_comb begin
      w_selData = in_data[0 +: WIDTH];
      for (int k = 1; k < N_IN; k++) begin
         if (in_sel == SEL_W'(k)) begin
            w_selData = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   assign w_acc = in_valid && r_inReady;
   assign w_adv = !r_oValid || out_ready;

   // The skid entry always leaves before a new beat lands in it, so the skid
   // can only be loaded while the output stage is stalled and the skid is empty.
   always_comb begin
      w_oValidNext = r_oValid;
      w_oDataNext  = r_oData;
      w_oErrNext   = r_oErr;
      w_sValidNext = r_sValid;
      w_sDataNext  = r_sData;
      w_sErrNext   = r_sErr;
      if (w_adv) begin
         if (r_sValid) begin
            w_oValidNext = 1'b1;
            w_oDataNext  = r_sData;
            w_oErrNext   = r_sErr;
            if (w_acc) begin
               w_sDataNext = w_selData;
               w_sErrNext  = w_selErr;
            end else begin
               w_sValidNext = 1'b0;
            end
         end else if (w_acc) begin
            w_oValidNext = 1'b1;
            w_oDataNext  = w_selData;
            w_oErrNext   = w_selErr;
         end else begin
            w_oValidNext = 1'b0;
         end
      end else if (w_acc) begin
         w_sValidNext = 1'b1;
         w_sDataNext  = w_selData;
         w_sErrNext   = w_selErr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_oValid  <= 1'b0;
         r_oData   <= '0;
         r_oErr    <= 1'b0;
         r_sValid  <= 1'b0;
         r_sData   <= '0;
         r_sErr    <= 1'b0;
         r_inReady <= 1'b1;
      end else begin
         r_oValid  <= w_oValidNext;
         r_oData   <= w_oDataNext;
         r_oErr    <= w_oErrNext;
         r_sValid  <= w_sValidNext;
         r_sData   <= w_sDataNext;
         r_sErr    <= w_sErrNext;
         r_inReady <= !w_sValidNext;
      end
   end

   // Counted at accept time; a clear wins over a simultaneous erroring beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_errCnt <= '0;
      end else if (err_clr) begin
         r_errCnt <= '0;
      end else if (w_acc && w_selErr && (r_errCnt != LP_CNT_MAX)) begin
         r_errCnt <= r_errCnt + 1'b1;
      end
   end

   assign in_ready    = r_inReady;
   assign out_valid   = r_oValid;
   assign out_data    = r_oData;
   assign out_sel_err = r_oErr;
   assign err_cnt     = r_errCnt;

endmodule
